layer2_argmax: RTL and testbench

//  Downstream consumer of the layer-2 neuron array (node2_0..node2_{NUM_NODES-1}).

---
 rtl/layer2_argmax_if.sv | 36 +++
 rtl/layer2_argmax.sv | 137 +++++++++++++
 tb/tb_layer2_argmax.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/layer2_argmax_if.sv
// Handshake bundle between the layer-2 node array, the argmax scanner and the classifier output stage.
// The reject signal exists only when ARGMAX_THRESH_EN is defined.
interface layer2_argmax_if #(
  parameter int NUM_NODES = 5,
  parameter int IDX_W     = 3
);
  logic                   in_valid;
  logic [8*NUM_NODES-1:0] N_in;
  logic                   out_ready;
  logic                   out_valid;
  logic [IDX_W-1:0]       class_idx;
  logic [7:0]             class_score;
  logic                   busy;
  logic                   overflow;
`ifdef ARGMAX_THRESH_EN
  logic                   reject;

  modport slave (
    input  in_valid, N_in, out_ready,
    output out_valid, class_idx, class_score, busy, overflow, reject
  );
  modport master (
    output in_valid, N_in, out_ready,
    input  out_valid, class_idx, class_score, busy, overflow, reject
  );
`else
  modport slave (
    input  in_valid, N_in, out_ready,
    output out_valid, class_idx, class_score, busy, overflow
  );
  modport master (
    output in_valid, N_in, out_ready,
    input  out_valid, class_idx, class_score, busy, overflow
  );
`endif
endinterface

// File: rtl/layer2_argmax.sv
// Sequential argmax over the layer-2 node outputs with valid/ready result handshake.
// Optional reject threshold enabled by defining ARGMAX_THRESH_EN.
//
//  state  | meaning
//  IDLE   | waiting for delayed in_valid (dvalid) to snapshot N_in
//  SCAN   | comparing one snapshot lane per cycle against the running best
//  DONE   | result presented on out_valid until out_ready
module layer2_argmax #(
  parameter int NUM_NODES = 5,
  parameter int NODE_LAT  = 2,
  parameter int IDX_W     = 3,
  parameter int MIN_SCORE = 8
) (
  input logic            clk,
  input logic            reset,
  layer2_argmax_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state;
  logic [NODE_LAT-1:0]       dly;
  logic [NUM_NODES-1:0][7:0] snap;
  logic [IDX_W-1:0]          cnt;
  logic [IDX_W-1:0]          best_idx;
  logic [7:0]                best_val;
  logic                      out_valid_r;
  logic [IDX_W-1:0]          class_idx_r;
  logic [7:0]                class_score_r;
  logic                      overflow_r;

  logic             dvalid;
  logic             take;
  logic             drop;
  logic             last;
  logic             upd;
  logic [7:0]       lane_cur;
  logic [7:0]       nxt_val;
  logic [IDX_W-1:0] nxt_idx;

  assign dvalid = dly[NODE_LAT-1];
  // A DONE result being accepted frees the scanner in the same cycle.
  assign take   = dvalid && ((state == S_IDLE) || (state == S_DONE && bus.out_ready));
  assign drop   = dvalid && !take;
  assign last   = (cnt == IDX_W'(NUM_NODES - 1));

  always_comb begin
    lane_cur = snap[0];
    for (int k = 0; k < NUM_NODES; k++) begin
      if (cnt == IDX_W'(k)) lane_cur = snap[k];
    end
  end

  // Strict compare keeps the lowest index on ties.
  assign upd     = (lane_cur > best_val);
  assign nxt_val = upd ? lane_cur : best_val;
  assign nxt_idx = upd ? cnt : best_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly <= '0;
    end else begin
      dly[0] <= bus.in_valid;
      for (int i = 1; i < NODE_LAT; i++) dly[i] <= dly[i-1];
    end
  end

`ifdef ARGMAX_THRESH_EN
  logic reject_r;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      snap          <= '0;
      cnt           <= '0;
      best_idx      <= '0;
      best_val      <= '0;
      out_valid_r   <= 1'b0;
      class_idx_r   <= '0;
      class_score_r <= '0;
      overflow_r    <= 1'b0;
`ifdef ARGMAX_THRESH_EN
      reject_r      <= 1'b0;
`endif
    end else begin
      if (drop) overflow_r <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
          if (take) begin
            snap     <= bus.N_in;
            best_val <= bus.N_in[7:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          cnt      <= cnt + IDX_W'(1);
          if (last) begin
            state         <= S_DONE;
            out_valid_r   <= 1'b1;
            class_score_r <= nxt_val;
`ifdef ARGMAX_THRESH_EN
            if (nxt_val < 8'(MIN_SCORE)) begin
              class_idx_r <= IDX_W'(NUM_NODES);
              reject_r    <= 1'b1;
            end else begin
              class_idx_r <= nxt_idx;
              reject_r    <= 1'b0;
            end
`else
            class_idx_r   <= nxt_idx;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.class_idx   = class_idx_r;
  assign bus.class_score = class_score_r;
  assign bus.busy        = (state != S_IDLE);
  assign bus.overflow    = overflow_r;
`ifdef ARGMAX_THRESH_EN
  assign bus.reject      = reject_r;
`endif
endmodule

// File: tb/tb_layer2_argmax.sv
// Directed bench for layer2_argmax: reset, argmax values, ties, latency, back-pressure, mid-scan reset.
module tb_layer2_argmax;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  layer2_argmax_if #(.NUM_NODES(5), .IDX_W(3)) bus ();

  layer2_argmax #(.NUM_NODES(5), .NODE_LAT(2), .IDX_W(3), .MIN_SCORE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pack(input logic [7:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  // in_valid in the current cycle, lanes presented two cycles later; returns in the cycle after.
  task automatic send_sample(input logic [39:0] lanes);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    bus.N_in = lanes;
    tick;
    bus.N_in = 40'hA5A5A5A5A5;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    bool_seen_block: begin
      logic seen;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      bus.N_in = '1;
      #2;
      reset = 1'b0;
      repeat (3) tick;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.class_idx !== 3'd0 ||
          bus.class_score !== 8'd0 || bus.overflow !== 1'b0)
        begin errors++; $display("FAIL reset_outputs got ov=%b busy=%b idx=%0d score=%0d ovf=%b want all 0",
          bus.out_valid, bus.busy, bus.class_idx, bus.class_score, bus.overflow); end
      bus.in_valid = 1'b0;
      tick;
      reset = 1'b1;
      seen = 1'b0;
      repeat (8) begin tick; if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_release got activity=%b want 0", seen); end
    end
  endtask

  task automatic test_basic;
    int n;
    send_sample(pack(8'd10, 8'd200, 8'd35, 8'd7, 8'd90));
    wait_result(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL basic_latency got %0d cycles after scan start want 4", n); end
    checks++;
    if (bus.class_idx !== 3'd1 || bus.class_score !== 8'd200)
      begin errors++; $display("FAIL basic_result got idx=%0d score=%0d want idx=1 score=200", bus.class_idx, bus.class_score); end
    repeat (3) tick;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.class_idx !== 3'd1 || bus.class_score !== 8'd200)
      begin errors++; $display("FAIL basic_hold got ov=%b idx=%0d score=%0d want 1/1/200", bus.out_valid, bus.class_idx, bus.class_score); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL basic_accept got ov=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_tie_zero;
    logic [39:0] vec [4];
    logic [2:0]  eidx [4];
    logic [7:0]  escore [4];
    int n;
    vec[0] = pack(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);          eidx[0] = 3'd0; escore[0] = 8'd0;
    vec[1] = pack(8'd50, 8'd80, 8'd80, 8'd3, 8'd80);      eidx[1] = 3'd1; escore[1] = 8'd80;
    vec[2] = pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd255);        eidx[2] = 3'd4; escore[2] = 8'd255;
    vec[3] = pack(8'd255, 8'd254, 8'd255, 8'd0, 8'd255);  eidx[3] = 3'd0; escore[3] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      send_sample(vec[i]);
      wait_result(n);
      checks++;
      if (n !== 4 || bus.class_idx !== eidx[i] || bus.class_score !== escore[i])
        begin errors++; $display("FAIL tie_case%0d got lat=%0d idx=%0d score=%0d want lat=4 idx=%0d score=%0d",
          i, n, bus.class_idx, bus.class_score, eidx[i], escore[i]); end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    send_sample(pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5));
    wait_result(n);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.class_idx !== 3'd4 || bus.class_score !== 8'd5)
      begin errors++; $display("FAIL b2b_first got ov=%b idx=%0d score=%0d want 1/4/5", bus.out_valid, bus.class_idx, bus.class_score); end
    bus.N_in = pack(8'd9, 8'd40, 8'd40, 8'd12, 8'd3);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    bus.N_in = '0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.overflow !== 1'b0)
      begin errors++; $display("FAIL b2b_accept got ov=%b busy=%b ovf=%b want 0/1/0", bus.out_valid, bus.busy, bus.overflow); end
    wait_result(n);
    checks++;
    if (n !== 4 || bus.class_idx !== 3'd1 || bus.class_score !== 8'd40)
      begin errors++; $display("FAIL b2b_second got lat=%0d idx=%0d score=%0d want lat=4 idx=1 score=40", n, bus.class_idx, bus.class_score); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    send_sample(pack(8'd100, 8'd20, 8'd30, 8'd40, 8'd50));
    wait_result(n);
    send_sample(pack(8'd1, 8'd255, 8'd1, 8'd1, 8'd1));
    repeat (7) tick;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.class_idx !== 3'd0 || bus.class_score !== 8'd100)
      begin errors++; $display("FAIL bp_hold got ov=%b idx=%0d score=%0d want 1/0/100", bus.out_valid, bus.class_idx, bus.class_score); end
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", bus.overflow); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    repeat (3) tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b1)
      begin errors++; $display("FAIL bp_drain got ov=%b busy=%b ovf=%b want 0/0/1", bus.out_valid, bus.busy, bus.overflow); end
  endtask

  task automatic test_reset_midscan;
    logic seen;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    bus.N_in = pack(8'd10, 8'd200, 8'd35, 8'd7, 8'd90);
    tick;
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0)
      begin errors++; $display("FAIL midscan_reset got busy=%b ov=%b ovf=%b want 0/0/0", bus.busy, bus.out_valid, bus.overflow); end
    tick;
    reset = 1'b1;
    // Sample sitting in the delay line when reset hits must also vanish.
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin tick; if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midscan_after got activity=%b want 0", seen); end
  endtask

`ifdef ARGMAX_THRESH_EN
  task automatic test_thresh;
    int n;
    send_sample(pack(8'd3, 8'd7, 8'd1, 8'd0, 8'd2));
    wait_result(n);
    checks++;
    if (bus.class_idx !== 3'd5 || bus.reject !== 1'b1 || bus.class_score !== 8'd7)
      begin errors++; $display("FAIL thresh_reject got idx=%0d rej=%b score=%0d want 5/1/7", bus.class_idx, bus.reject, bus.class_score); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    send_sample(pack(8'd3, 8'd8, 8'd1, 8'd0, 8'd2));
    wait_result(n);
    checks++;
    if (bus.class_idx !== 3'd1 || bus.reject !== 1'b0 || bus.class_score !== 8'd8)
      begin errors++; $display("FAIL thresh_pass got idx=%0d rej=%b score=%0d want 1/0/8", bus.class_idx, bus.reject, bus.class_score); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.N_in = '0;
    test_reset;
    test_basic;
    test_tie_zero;
    test_back_to_back;
    test_backpressure;
    test_reset_midscan;
`ifdef ARGMAX_THRESH_EN
    test_thresh;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
